pio_event_poll_master: RTL



---
 rtl/pio_event_poll_master.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pio_event_poll_master.sv
// Avalon-MM master that polls a single-bit PIO slave, counts rising edges and acknowledges each with a 1-then-0 write.
// Optional build macro PIO_POLL_FILTER_EN: an edge needs two consecutive high polls after a low poll.
module pio_event_poll_master #(
   parameter int POLL_CYCLES = 16,
   parameter int COUNT_W     = 16,
   parameter int ACK_HOLD    = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               irq_ack,
   output logic [1:0]         m_address,
   output logic               m_chipselect,
   output logic               m_write_n,
   output logic [31:0]        m_writedata,
   input  logic [31:0]        m_readdata,
   output logic [COUNT_W-1:0] event_count,
   output logic               irq,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT    = 3'd1,
      RD_ADDR = 3'd2,
      RD_CAP  = 3'd3,
      WR_SET  = 3'd4,
      WR_CLR  = 3'd5
   } state_t;

   // From IDLE the first read lands POLL_CYCLES after the enable is seen; between polls
   // RD_ADDR and RD_CAP already use two of the period, so WAIT covers the rest.
   localparam logic [15:0] START_CNT  = 16'(POLL_CYCLES - 1);
   localparam logic [15:0] RELOAD_CNT = 16'(POLL_CYCLES - 2);
   localparam logic [7:0]  HOLD_CNT   = 8'(ACK_HOLD);

   state_t      state_r;
   state_t      resume_s;
   logic [15:0] wait_cnt_r;
   logic [7:0]  hold_cnt_r;
   logic        prev_sample_r;
`ifdef PIO_POLL_FILTER_EN
   logic        prev2_sample_r;
`endif
   logic        cur_s;
   logic        edge_s;
   logic        rd_unused_s;

   assign rd_unused_s = |m_readdata[31:1];

   // Edge qualification on the sample returned by the slave during RD_CAP
   always_comb begin
      cur_s = m_readdata[0];
`ifdef PIO_POLL_FILTER_EN
      edge_s = cur_s & prev_sample_r & ~prev2_sample_r;
`else
      edge_s = cur_s & ~prev_sample_r;
`endif
   end

   // Where a finished poll sequence goes next; a two-cycle period skips WAIT entirely
   always_comb begin
      if (!enable) begin
         resume_s = IDLE;
      end else if (RELOAD_CNT == 16'd0) begin
         resume_s = RD_ADDR;
      end else begin
         resume_s = WAIT;
      end
   end

   // Poll/acknowledge sequencer with registered bus and status outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r        <= IDLE;
         wait_cnt_r     <= 16'd0;
         hold_cnt_r     <= 8'd0;
         prev_sample_r  <= 1'b0;
`ifdef PIO_POLL_FILTER_EN
         prev2_sample_r <= 1'b0;
`endif
         m_address      <= 2'b00;
         m_chipselect   <= 1'b0;
         m_write_n      <= 1'b1;
         m_writedata    <= 32'd0;
         event_count    <= '0;
         irq            <= 1'b0;
         busy           <= 1'b0;
      end else begin
         m_address <= 2'b00;
         // A set in RD_CAP below overrides this clear when both land together
         if (irq_ack) begin
            irq <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               if (enable) begin
                  state_r    <= WAIT;
                  wait_cnt_r <= START_CNT;
               end else begin
                  state_r    <= IDLE;
               end
            end
            WAIT: begin
               if (!enable) begin
                  state_r <= IDLE;
               end else if (wait_cnt_r <= 16'd1) begin
                  state_r      <= RD_ADDR;
                  wait_cnt_r   <= 16'd0;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b1;
                  busy         <= 1'b1;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 16'd1;
               end
            end
            RD_ADDR: begin
               state_r      <= RD_CAP;
               m_chipselect <= 1'b0;
            end
            RD_CAP: begin
               prev_sample_r  <= cur_s;
`ifdef PIO_POLL_FILTER_EN
               prev2_sample_r <= prev_sample_r;
`endif
               if (edge_s) begin
                  state_r      <= WR_SET;
                  hold_cnt_r   <= HOLD_CNT;
                  event_count  <= event_count + COUNT_W'(1);
                  irq          <= 1'b1;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= 32'd1;
               end else begin
                  state_r      <= resume_s;
                  wait_cnt_r   <= RELOAD_CNT;
                  m_chipselect <= (resume_s == RD_ADDR);
                  busy         <= (resume_s == RD_ADDR);
               end
            end
            WR_SET: begin
               if (hold_cnt_r == 8'd0) begin
                  state_r      <= WR_CLR;
                  m_chipselect <= 1'b1;
                  m_write_n    <= 1'b0;
                  m_writedata  <= 32'd0;
               end else begin
                  hold_cnt_r   <= hold_cnt_r - 8'd1;
                  m_chipselect <= 1'b0;
                  m_write_n    <= 1'b1;
                  m_writedata  <= 32'd1;
               end
            end
            WR_CLR: begin
               state_r      <= resume_s;
               wait_cnt_r   <= RELOAD_CNT;
               m_chipselect <= (resume_s == RD_ADDR);
               m_write_n    <= 1'b1;
               m_writedata  <= 32'd0;
               busy         <= (resume_s == RD_ADDR);
            end
            default: begin
               state_r      <= IDLE;
               m_chipselect <= 1'b0;
               m_write_n    <= 1'b1;
               m_writedata  <= 32'd0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule
